// File: rtl/modmul_responder_if.sv
// Multiply-port bundle between the butterfly unit (master) and the modular-multiplier responder (slave).
interface modmul_responder_if #(
    parameter int WIDTH = 23
);
    logic             in_valid;
    logic [WIDTH-1:0] opt1;
    logic [WIDTH-1:0] opt2;
    logic             out_valid;
    logic [WIDTH-1:0] mul_result;

    modport master (output in_valid, opt1, opt2, input out_valid, mul_result);
    modport slave  (input in_valid, opt1, opt2, output out_valid, mul_result);
endinterface

// File: rtl/modmul_responder.sv
// Five-stage pipelined (opt1*opt2) mod Q for Q = 2^23-2^13+1, one pair per cycle.
// Optional MODMUL_STALL_EN adds a ce input that freezes the whole pipeline.
module modmul_responder #(
    parameter int WIDTH = 23,
    parameter int Q     = 8380417
) (
    input  logic              clk,
    input  logic              rst,
`ifdef MODMUL_STALL_EN
    input  logic              ce,
`endif
    modmul_responder_if.slave bus
);

    localparam logic [23:0] Q1 = 24'(Q);
    localparam logic [23:0] Q2 = 24'(2 * Q);

    // The folding arithmetic below only holds for this modulus and width.
    generate
        if (Q != 8380417 || WIDTH != 23) begin : g_bad_cfg
            $error("modmul_responder supports only WIDTH=23, Q=8380417");
        end
    endgenerate

    logic adv;
`ifdef MODMUL_STALL_EN
    assign adv = ce;
`else
    assign adv = 1'b1;
`endif

    logic             v1_q, v1_d, v2_q, v2_d, v3_q, v3_d, v4_q, v4_d, v5_q, v5_d;
    logic [WIDTH-1:0] a1_q, a1_d, b1_q, b1_d;
    logic [45:0]      p2_q, p2_d;
    logic [36:0]      r1_q, r1_d;
    logic [23:0]      r2_q, r2_d;
    logic [WIDTH-1:0] res_q, res_d;

    logic [45:0] prod;
    logic [36:0] fold1;
    logic [27:0] fold2a;
    logic [23:0] fold2b;
    logic [23:0] reduced;

    always_comb begin
        prod = 46'(a1_q) * 46'(b1_q);
        // 2^23 == 2^13-1 (mod Q); R1 < 2^36 + 2^23 fits in 37 bits.
        fold1 = {14'b0, p2_q[22:0]} + {1'b0, p2_q[45:23], 13'b0} - {14'b0, p2_q[45:23]};
        // Two folds bring R1 below 2^23 + 17*(2^13-1), i.e. under 2Q.
        fold2a = {5'b0, r1_q[22:0]} + {1'b0, r1_q[36:23], 13'b0} - {14'b0, r1_q[36:23]};
        fold2b = {1'b0, fold2a[22:0]} + {6'b0, fold2a[27:23], 13'b0} - {19'b0, fold2a[27:23]};
        if (r2_q >= Q2) begin
            reduced = r2_q - Q2;
        end else if (r2_q >= Q1) begin
            reduced = r2_q - Q1;
        end else begin
            reduced = r2_q;
        end

        v1_d  = v1_q;
        a1_d  = a1_q;
        b1_d  = b1_q;
        v2_d  = v2_q;
        p2_d  = p2_q;
        v3_d  = v3_q;
        r1_d  = r1_q;
        v4_d  = v4_q;
        r2_d  = r2_q;
        v5_d  = v5_q;
        res_d = res_q;
        if (adv) begin
            v1_d  = bus.in_valid;
            a1_d  = bus.opt1;
            b1_d  = bus.opt2;
            v2_d  = v1_q;
            p2_d  = prod;
            v3_d  = v2_q;
            r1_d  = fold1;
            v4_d  = v3_q;
            r2_d  = fold2b;
            v5_d  = v4_q;
            res_d = reduced[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q  <= 1'b0;
            a1_q  <= '0;
            b1_q  <= '0;
            v2_q  <= 1'b0;
            p2_q  <= '0;
            v3_q  <= 1'b0;
            r1_q  <= '0;
            v4_q  <= 1'b0;
            r2_q  <= '0;
            v5_q  <= 1'b0;
            res_q <= '0;
        end else begin
            v1_q  <= v1_d;
            a1_q  <= a1_d;
            b1_q  <= b1_d;
            v2_q  <= v2_d;
            p2_q  <= p2_d;
            v3_q  <= v3_d;
            r1_q  <= r1_d;
            v4_q  <= v4_d;
            r2_q  <= r2_d;
            v5_q  <= v5_d;
            res_q <= res_d;
        end
    end

    assign bus.out_valid  = v5_q;
    assign bus.mul_result = res_q;

endmodule

// File: tb/tb_modmul_responder.sv
// Directed and randomized checks of modmul_responder latency, reduction, reset and stall behaviour.
module tb_modmul_responder;

    localparam int QV = 8380417;

    logic clk = 1'b0;
    logic rst;
    logic ce;
    int   n_pass  = 0;
    int   n_total = 0;

    modmul_responder_if #(.WIDTH(23)) bus ();

    modmul_responder #(.WIDTH(23), .Q(QV)) dut (
        .clk (clk),
        .rst (rst),
`ifdef MODMUL_STALL_EN
        .ce  (ce),
`endif
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [22:0] gold(input logic [22:0] a, input logic [22:0] b);
        longint unsigned x;
        x = longint'(a) * longint'(b);
        return 23'(x % 64'd8380417);
    endfunction

    function automatic logic [22:0] pick();
        case ($urandom_range(0, 4))
            0:       return 23'd0;
            1:       return 23'(QV - 1);
            2:       return 23'($urandom_range(QV, 8388607));
            default: return 23'($urandom_range(0, 8388607));
        endcase
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        ce = 1'b1;
        bus.in_valid = 1'b0;
        bus.opt1 = '0;
        bus.opt2 = '0;
        tick();
        tick();
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            n_total++;
            if (bus.out_valid !== 1'b0) $display("FAIL reset_valid[%0d] got %b want 0", k, bus.out_valid);
            else n_pass++;
            n_total++;
            if (bus.mul_result !== 23'd0) $display("FAIL reset_result[%0d] got %0d want 0", k, bus.mul_result);
            else n_pass++;
        end
    endtask

    task automatic test_single(input string name, input logic [22:0] a, input logic [22:0] b,
                               input logic [22:0] want);
        int          lat;
        int          cnt;
        logic [22:0] res;
        lat = -1;
        cnt = 0;
        res = '0;
        bus.in_valid = 1'b1;
        bus.opt1 = a;
        bus.opt2 = b;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 1) begin
                bus.in_valid = 1'b0;
                bus.opt1 = '0;
                bus.opt2 = '0;
            end
            if (bus.out_valid === 1'b1) begin
                cnt++;
                if (lat < 0) begin
                    lat = k;
                    res = bus.mul_result;
                end
            end
        end
        n_total++;
        if (lat != 5) $display("FAIL %s_latency got %0d want 5", name, lat);
        else n_pass++;
        n_total++;
        if (cnt != 1) $display("FAIL %s_valid_count got %0d want 1", name, cnt);
        else n_pass++;
        n_total++;
        if (res !== want) $display("FAIL %s_result got %0d want %0d", name, res, want);
        else n_pass++;
    endtask

    task automatic test_stream();
        logic        vh[210];
        logic [22:0] expq[$];
        logic [22:0] a, b, e;
        logic        v, exp_v;
        for (int i = 0; i < 210; i++) begin
            v = 1'b0;
            a = '0;
            b = '0;
            if (i < 200) begin
                v = ($urandom_range(0, 3) != 0);
                a = pick();
                b = pick();
            end
            vh[i] = v;
            bus.in_valid = v;
            bus.opt1 = a;
            bus.opt2 = b;
            if (v) expq.push_back(gold(a, b));
            tick();
            exp_v = (i >= 4) ? vh[i-4] : 1'b0;
            n_total++;
            if (bus.out_valid !== exp_v) $display("FAIL stream_valid[%0d] got %b want %b", i, bus.out_valid, exp_v);
            else n_pass++;
            if (bus.out_valid === 1'b1) begin
                n_total++;
                if (expq.size() == 0) begin
                    $display("FAIL stream_extra[%0d] got response %0d want none", i, bus.mul_result);
                end else begin
                    e = expq.pop_front();
                    if (bus.mul_result !== e) $display("FAIL stream_result[%0d] got %0d want %0d", i, bus.mul_result, e);
                    else n_pass++;
                end
            end
        end
        bus.in_valid = 1'b0;
        n_total++;
        if (expq.size() != 0) $display("FAIL stream_drain got %0d pending want 0", expq.size());
        else n_pass++;
    endtask

    task automatic test_reset_midstream();
        int          lat;
        int          cnt;
        logic [22:0] res;
        for (int k = 0; k < 4; k++) begin
            bus.in_valid = 1'b1;
            bus.opt1 = 23'(100 + k);
            bus.opt2 = 23'(200 + k);
            tick();
        end
        rst = 1'b1;
        bus.opt1 = 23'd5;
        bus.opt2 = 23'd6;
        tick();
        n_total++;
        if (bus.out_valid !== 1'b0) $display("FAIL midrst_flush got %b want 0", bus.out_valid);
        else n_pass++;
        rst = 1'b0;
        bus.opt1 = 23'd3000;
        bus.opt2 = 23'd4000;
        lat = -1;
        cnt = 0;
        res = '0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (k == 1) bus.in_valid = 1'b0;
            if (bus.out_valid === 1'b1) begin
                cnt++;
                if (lat < 0) begin
                    lat = k;
                    res = bus.mul_result;
                end
            end
        end
        n_total++;
        if (cnt != 1) $display("FAIL midrst_count got %0d want 1", cnt);
        else n_pass++;
        n_total++;
        if (lat != 5) $display("FAIL midrst_latency got %0d want 5", lat);
        else n_pass++;
        n_total++;
        if (res !== 23'd3619583) $display("FAIL midrst_result got %0d want 3619583", res);
        else n_pass++;
    endtask

`ifdef MODMUL_STALL_EN
    task automatic test_stall();
        logic        ev;
        logic [22:0] er;
        for (int c = 0; c < 16; c++) begin
            ce = !(c >= 5 && c <= 7);
            bus.in_valid = (c <= 2) || (c >= 5 && c <= 7);
            case (c)
                0:       begin bus.opt1 = 23'd8388607; bus.opt2 = 23'd8388607; end
                1:       begin bus.opt1 = 23'd1753;    bus.opt2 = 23'd1;       end
                2:       begin bus.opt1 = 23'(QV - 1); bus.opt2 = 23'(QV - 1); end
                default: begin bus.opt1 = 23'd7;       bus.opt2 = 23'd9;       end
            endcase
            tick();
            ev = (c + 1 >= 5) && (c + 1 <= 10);
            er = (c + 1 == 9) ? 23'd1753 : (c + 1 == 10) ? 23'd1 : 23'd32764;
            n_total++;
            if (bus.out_valid !== ev) $display("FAIL stall_valid[%0d] got %b want %b", c + 1, bus.out_valid, ev);
            else n_pass++;
            if (ev) begin
                n_total++;
                if (bus.mul_result !== er) $display("FAIL stall_result[%0d] got %0d want %0d", c + 1, bus.mul_result, er);
                else n_pass++;
            end
        end
        ce = 1'b1;
        bus.in_valid = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_single("qm1_sq",   23'(QV - 1), 23'(QV - 1), 23'd1);
        test_single("max_sq",   23'd8388607, 23'd8388607, 23'd32764);
        test_single("zero",     23'd0,       23'(QV - 1), 23'd0);
        test_single("ident",    23'd1753,    23'd1,       23'd1753);
        test_single("max_x1",   23'd8388607, 23'd1,       23'd8190);
        test_single("q_x5",     23'(QV),     23'd5,       23'd0);
        test_stream();
        test_reset_midstream();
`ifdef MODMUL_STALL_EN
        test_stall();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got no finish want finish");
        $fatal(1, "timeout");
    end

endmodule
